// File: rtl/data_memory_lsu_if.sv
// Pipeline-to-data-memory bus for the MEM stage.
// The pipeline side uses the master modport and the memory uses the slave modport.
interface data_memory_lsu_if;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        MemWriteM;
    logic        MemReadM;
    logic [2:0]  Funct3M;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;

    modport master (
        output ALUResultM, WriteDataM, MemWriteM, MemReadM, Funct3M,
        input  ReadDataM, StallM, MisalignM
    );
    modport slave (
        input  ALUResultM, WriteDataM, MemWriteM, MemReadM, Funct3M,
        output ReadDataM, StallM, MisalignM
    );
endinterface

// File: rtl/data_memory_lsu.sv
// MEM-stage data memory with RV32I byte, halfword and word loads and stores.
// Byte lanes are little-endian, and the memory can insert configurable wait states,
// signalled to the hazard unit through StallM.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned halfword/word accesses on MisalignM
// and suppress them. Without it, such accesses are aligned down.
module data_memory_lsu #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    data_memory_lsu_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int WL = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              req, is_store, is_load, done, stall, misal, trap, we;
    logic [2:0]        f3;
    logic [1:0]        lane, elane;
    logic [AW-1:0]     idx;
    logic              is_half, is_word;
    logic [3:0]        wmask;
    logic [31:0]       wword, word, sh, rdata;
    logic              unused_hi;

    assign req      = bus.MemWriteM | bus.MemReadM;
    assign is_store = bus.MemWriteM;
    assign is_load  = bus.MemReadM & ~bus.MemWriteM;
    assign f3       = bus.Funct3M;
    assign lane     = bus.ALUResultM[1:0];
    assign idx      = bus.ALUResultM[AW+1:2];
    // Address bits above the array wrap away.
    assign unused_hi = ^bus.ALUResultM[31:AW+2];

    // For stores, only funct3 001 is a halfword access. For loads, both lh and lhu are.
    assign is_half = is_store ? (f3 == 3'b001) : (f3[1:0] == 2'b01);
    assign is_word = (f3 == 3'b010);
    // Clear the low address bits that a halfword or word access cannot use.
    assign elane   = is_word ? 2'b00 : (is_half ? {lane[1], 1'b0} : lane);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misal = (is_half & lane[0]) | (is_word & (lane != 2'b00));
`else
    assign misal = 1'b0;
`endif
    assign trap = done & misal;

    // State register. Reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic, stall and completion strobe. All are forced low while reset is held.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall   = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (req) begin
                if (WAIT_CYCLES == 0) begin
                    done = 1'b1;
                end else begin
                    stall   = 1'b1;
                    state_n = WAIT;
                    cnt_n   = CNT_W'(WL);
                end
            end
            WAIT: begin
                if (!req) begin
                    state_n = IDLE;
                end else if (cnt != '0) begin
                    stall = 1'b1;
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (!rst) begin
            stall = 1'b0;
            done  = 1'b0;
        end
    end

    // Build the store lane mask. The store data is replicated across lanes so that the mask alone selects the bytes.
    always_comb begin
        wmask = 4'b0000;
        wword = {4{bus.WriteDataM[7:0]}};
        case (f3)
            3'b000: wmask = 4'b0001 << elane;
            3'b001: begin
                wmask = 4'b0011 << elane;
                wword = {2{bus.WriteDataM[15:0]}};
            end
            3'b010: begin
                wmask = 4'b1111;
                wword = bus.WriteDataM;
            end
            default: wmask = 4'b0000;
        endcase
    end

    assign we = done & is_store & ~trap;

    // Byte-lane write that commits only on the completing edge. The array is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    assign word = mem[idx];
    assign sh   = word >> {elane, 3'b000};

    // Combinational load extraction. It is zero unless a load completes this cycle.
    always_comb begin
        rdata = 32'h0;
        if (done & is_load & ~trap) begin
            case (f3)
                3'b000:  rdata = {{24{sh[7]}}, sh[7:0]};
                3'b001:  rdata = {{16{sh[15]}}, sh[15:0]};
                3'b010:  rdata = sh;
                3'b100:  rdata = {24'h0, sh[7:0]};
                3'b101:  rdata = {16'h0, sh[15:0]};
                default: rdata = 32'h0;
            endcase
        end
    end

    assign bus.ReadDataM = rdata;
    assign bus.StallM    = stall;
    assign bus.MisalignM = trap;
endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu.
// It uses one zero-wait instance and one three-wait instance, with expected load results queued on issue and checked on completion.
module tb_data_memory_lsu;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam int W1 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_memory_lsu_if b0 ();
    data_memory_lsu_if b1 ();

    data_memory_lsu #(.DEPTH_WORDS(256), .WAIT_CYCLES(0),  .CNT_W(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
    data_memory_lsu #(.DEPTH_WORDS(256), .WAIT_CYCLES(W1), .CNT_W(4)) u1 (.clk(clk), .rst(rst), .bus(b1));

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];
    logic        mis_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic w, input logic r, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        b0.MemWriteM = w; b0.MemReadM = r; b0.Funct3M = f3;
        b0.ALUResultM = a; b0.WriteDataM = wd;
    endtask

    task automatic drive1(input logic w, input logic r, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        b1.MemWriteM = w; b1.MemReadM = r; b1.Funct3M = f3;
        b1.ALUResultM = a; b1.WriteDataM = wd;
    endtask

    // One access on the zero-wait instance. It must complete in the cycle it is presented.
    task automatic acc0(input string tag, input logic w, input logic r, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_mis);
        logic [31:0] e;
        logic        m;
        @(posedge clk); #1;
        drive0(w, r, f3, a, wd);
        exp_q.push_back(exp_rd);
        mis_q.push_back(exp_mis);
        @(negedge clk);
        chk({tag, ".stall"}, {31'h0, b0.StallM}, 32'h0);
        e = exp_q.pop_front();
        m = mis_q.pop_front();
        chk({tag, ".rd"}, b0.ReadDataM, e);
        chk({tag, ".mis"}, {31'h0, b0.MisalignM}, {31'h0, m});
    endtask

    // One access on the wait-state instance. It counts stall cycles and checks the data on the completing cycle.
    task automatic acc1(input string tag, input logic w, input logic r, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
        int  nst;
        bit  fin;
        logic [31:0] e;
        logic        m;
        nst = 0;
        fin = 1'b0;
        @(posedge clk); #1;
        drive1(w, r, f3, a, wd);
        exp_q.push_back(exp_rd);
        mis_q.push_back(1'b0);
        for (int i = 0; i < 16 && !fin; i++) begin
            @(negedge clk);
            if (b1.StallM === 1'b0) fin = 1'b1;
            else nst++;
        end
        e = exp_q.pop_front();
        m = mis_q.pop_front();
        if (!fin) begin
            chk({tag, ".timeout"}, 32'h1, 32'h0);
        end else begin
            chk({tag, ".rd"}, b1.ReadDataM, e);
            chk({tag, ".mis"}, {31'h0, b1.MisalignM}, {31'h0, m});
        end
        chk({tag, ".stalls"}, nst, W1);
    endtask

    initial begin
        // Hold reset with requests pending. All outputs must stay low.
        rst = 1'b0;
        drive0(1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
        drive1(1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
        @(negedge clk); @(negedge clk);
        chk("rst.stall1", {31'h0, b1.StallM}, 32'h0);
        chk("rst.rd1",    b1.ReadDataM, 32'h0);
        chk("rst.rd0",    b0.ReadDataM, 32'h0);
        chk("rst.mis0",   {31'h0, b0.MisalignM}, 32'h0);
        drive0(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Zero-wait word store then load.
        acc0("sw0",   1, 0, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        acc0("lw0",   0, 1, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        // Byte store into the top lane, then signed and unsigned byte loads.
        acc0("sw1",   1, 0, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0);
        acc0("sb",    1, 0, 3'b000, 32'h13, 32'h12345680, 32'h0, 1'b0);
        acc0("lw_sb", 0, 1, 3'b010, 32'h10, 32'h0, 32'h80223344, 1'b0);
        acc0("lb",    0, 1, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        acc0("lbu",   0, 1, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0);
        // Halfword store into the upper half.
        acc0("sh",    1, 0, 3'b001, 32'h12, 32'h1234A5A5, 32'h0, 1'b0);
        acc0("lw_sh", 0, 1, 3'b010, 32'h10, 32'h0, 32'hA5A53344, 1'b0);
        acc0("lh",    0, 1, 3'b001, 32'h12, 32'h0, 32'hFFFFA5A5, 1'b0);
        acc0("lhu",   0, 1, 3'b101, 32'h12, 32'h0, 32'h0000A5A5, 1'b0);
        acc0("lh_lo", 0, 1, 3'b001, 32'h10, 32'h0, 32'h00003344, 1'b0);
        acc0("lb_lo", 0, 1, 3'b000, 32'h10, 32'h0, 32'h00000044, 1'b0);
        // Address wrap. 0x400 aliases word 0.
        acc0("sw_wr", 1, 0, 3'b010, 32'h400, 32'h00000055, 32'h0, 1'b0);
        acc0("lw_wr", 0, 1, 3'b010, 32'h000, 32'h0, 32'h00000055, 1'b0);
        // An illegal store funct3 must not write.
        acc0("s011",  1, 0, 3'b011, 32'h000, 32'hFFFFFFFF, 32'h0, 1'b0);
        acc0("lw_nw", 0, 1, 3'b010, 32'h000, 32'h0, 32'h00000055, 1'b0);
        acc0("l011",  0, 1, 3'b011, 32'h000, 32'h0, 32'h0, 1'b0);
        acc0("l110",  0, 1, 3'b110, 32'h000, 32'h0, 32'h0, 1'b0);
        // When write and read are both asserted, the access is a store and reads as zero.
        acc0("rw",    1, 1, 3'b010, 32'h08, 32'h00000066, 32'h0, 1'b0);
        acc0("lw_rw", 0, 1, 3'b010, 32'h08, 32'h0, 32'h00000066, 1'b0);
        acc0("idle",  0, 0, 3'b010, 32'h08, 32'h0, 32'h0, 1'b0);
        // Misaligned word store: trapped, or aligned down to word 0.
        acc0("sw_mis", 1, 0, 3'b010, 32'h02, 32'hCAFEF00D, 32'h0, TRAP);
        acc0("lw_chk", 0, 1, 3'b010, 32'h00, 32'h0, TRAP ? 32'h00000055 : 32'hCAFEF00D, 1'b0);
        acc0("lw_mis", 0, 1, 3'b010, 32'h02, 32'h0, TRAP ? 32'h0 : 32'hCAFEF00D, TRAP);
        drive0(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

        // Wait-state instance: back-to-back accesses, each stalls three cycles.
        acc1("w.sw",  1, 0, 3'b010, 32'h10, 32'h0BADF00D, 32'h0);
        acc1("w.lw",  0, 1, 3'b010, 32'h10, 32'h0, 32'h0BADF00D);
        acc1("w.lb",  0, 1, 3'b000, 32'h11, 32'h0, 32'hFFFFFFF0);
        acc1("w.sw2", 1, 0, 3'b010, 32'h20, 32'h11111111, 32'h0);

        // Reset during cycle 2 of a store. The stall drops at once and the store is lost.
        @(posedge clk); #1;
        drive1(1'b1, 1'b0, 3'b010, 32'h20, 32'h22222222);
        @(negedge clk);
        chk("rs.c1stall", {31'h0, b1.StallM}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rs.stall", {31'h0, b1.StallM}, 32'h0);
        chk("rs.rd",    b1.ReadDataM, 32'h0);
        drive1(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        acc1("rs.lw", 0, 1, 3'b010, 32'h20, 32'h0, 32'h11111111);
        drive1(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
